// File: rtl/fetch_sequencer.sv
// Program-counter and fetch controller for a combinational program memory.
// Registers each fetched instruction, hands it to decode over valid/ready, and redirects or halts.
module fetch_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 17,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   inClock,
  input  logic                   inReset,
  input  logic                   inStart,
  input  logic [ADDR_WIDTH-1:0]  inStartAddress,
  input  logic                   inBranchTaken,
  input  logic [ADDR_WIDTH-1:0]  inBranchTarget,
  input  logic [INSTR_WIDTH-1:0] inInstr,
  input  logic                   inReady,
  output logic [ADDR_WIDTH-1:0]  outAddress,
  output logic [INSTR_WIDTH-1:0] outInstr,
  output logic                   outValid,
  output logic [ADDR_WIDTH-1:0]  outPC,
  output logic                   outHalted,
  output logic [CNT_WIDTH-1:0]   outFetchCount
);

  // state | meaning
  // IDLE  | after reset, no fetch until start
  // FETCH | loading instructions, presenting them downstream
  // HALT  | exit instruction seen, waiting for restart

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]  opc_q, opc_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   slot_free;
  logic                   is_exit;

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      opc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      opc_q   <= opc_d;
      count_q <= count_d;
    end
  end

  assign slot_free = !valid_q || inReady;
  assign is_exit   = (inInstr == '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    opc_d   = opc_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (inStart) begin
          pc_d    = inStartAddress;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // A branch flushes whatever is held, even an instruction being accepted this edge.
        if (inBranchTaken) begin
          pc_d    = inBranchTarget;
          valid_d = 1'b0;
        end else if (slot_free) begin
          if (is_exit) begin
            valid_d = 1'b0;
            state_d = HALT;
          end else begin
            instr_d = inInstr;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_WIDTH'(1);
            if (count_q != '1) count_d = count_q + CNT_WIDTH'(1);
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (inStart) begin
          pc_d    = inStartAddress;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign outAddress    = pc_q;
  assign outInstr      = instr_q;
  assign outValid      = valid_q;
  assign outPC         = opc_q;
  assign outHalted     = (state_q == HALT);
  assign outFetchCount = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a model program memory driven from the
// DUT address, with hand-computed expectations checked step by step.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr;
  logic        br;
  logic [7:0]  br_tgt;
  logic [16:0] instr;
  logic        ready;
  logic [7:0]  address;
  logic [16:0] out_instr;
  logic        valid;
  logic [7:0]  out_pc;
  logic        halted;
  logic [15:0] fcount;

  logic [16:0] mem [256];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign instr = mem[address];

  fetch_sequencer dut (
    .inClock(clk),
    .inReset(rst),
    .inStart(start),
    .inStartAddress(start_addr),
    .inBranchTaken(br),
    .inBranchTarget(br_tgt),
    .inInstr(instr),
    .inReady(ready),
    .outAddress(address),
    .outInstr(out_instr),
    .outValid(valid),
    .outPC(out_pc),
    .outHalted(halted),
    .outFetchCount(fcount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},   32'(address),   32'h0);
    check({tag, "_instr"},  32'(out_instr), 32'h0);
    check({tag, "_valid"},  32'(valid),     32'h0);
    check({tag, "_pc"},     32'(out_pc),    32'h0);
    check({tag, "_halted"}, 32'(halted),    32'h0);
    check({tag, "_count"},  32'(fcount),    32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 17'h100 + 17'(i);
    mem[0] = 17'b10001001000011110;
    mem[1] = 17'h0;
    rst = 1'b1; start = 1'b0; start_addr = 8'h00; br = 1'b0; br_tgt = 8'h00; ready = 1'b1;
    #2;
    check_reset_values("rst");
    @(negedge clk);
    rst = 1'b0;

    // single instruction then exit
    start = 1'b1; start_addr = 8'h00;
    tick();
    start = 1'b0;
    check("t1_addr_start", 32'(address), 32'h00);
    check("t1_valid_start", 32'(valid), 32'h0);
    tick();
    check("t1_valid", 32'(valid), 32'h1);
    check("t1_instr", 32'(out_instr), 32'h1121E);
    check("t1_pc", 32'(out_pc), 32'h00);
    tick();
    check("t1_valid_gone", 32'(valid), 32'h0);
    check("t1_halted", 32'(halted), 32'h1);
    check("t1_count", 32'(fcount), 32'h1);
    check("t1_addr_halt", 32'(address), 32'h01);

    // backpressure hold
    mem[0] = 17'h00AA; mem[1] = 17'h00BB; mem[2] = 17'h00CC; mem[3] = 17'h00DD;
    start = 1'b1; start_addr = 8'h00;
    tick();
    start = 1'b0;
    check("t2_halted_clr", 32'(halted), 32'h0);
    tick();
    check("t2_first", 32'(out_instr), 32'h00AA);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_hold_instr", 32'(out_instr), 32'h00AA);
      check("t2_hold_valid", 32'(valid), 32'h1);
      check("t2_hold_addr", 32'(address), 32'h01);
    end
    ready = 1'b1;
    tick();
    check("t2_second", 32'(out_instr), 32'h00BB);
    check("t2_second_pc", 32'(out_pc), 32'h01);
    tick();
    check("t2_third", 32'(out_instr), 32'h00CC);
    check("t2_count", 32'(fcount), 32'h4);

    // branch flush while stalled
    mem[8'h40] = 17'h1ABCD; mem[8'h41] = 17'h0;
    ready = 1'b0; br = 1'b1; br_tgt = 8'h40;
    tick();
    br = 1'b0; ready = 1'b1;
    check("t3_flush_valid", 32'(valid), 32'h0);
    check("t3_addr", 32'(address), 32'h40);
    tick();
    check("t3_tgt_instr", 32'(out_instr), 32'h1ABCD);
    check("t3_tgt_pc", 32'(out_pc), 32'h40);
    check("t3_tgt_valid", 32'(valid), 32'h1);
    check("t3_count", 32'(fcount), 32'h5);
    tick();
    check("t3_halted", 32'(halted), 32'h1);

    // wrap across the top of the address space
    mem[8'hFE] = 17'h0FE0; mem[8'hFF] = 17'h0FF0; mem[8'h00] = 17'h0000F; mem[8'h01] = 17'h0;
    start = 1'b1; start_addr = 8'hFE;
    tick();
    start = 1'b0;
    check("t4_addr", 32'(address), 32'hFE);
    tick();
    check("t4_pc_fe", 32'(out_pc), 32'hFE);
    tick();
    check("t4_pc_ff", 32'(out_pc), 32'hFF);
    tick();
    check("t4_pc_00", 32'(out_pc), 32'h00);
    check("t4_instr_00", 32'(out_instr), 32'h0000F);
    tick();
    check("t4_halted", 32'(halted), 32'h1);
    check("t4_addr_halt", 32'(address), 32'h01);
    check("t4_count", 32'(fcount), 32'h8);

    // branch ignored in HALT, then restart at 5
    br = 1'b1; br_tgt = 8'h20;
    tick();
    br = 1'b0;
    check("t6_still_halted", 32'(halted), 32'h1);
    check("t6_addr_kept", 32'(address), 32'h01);
    check("t6_valid", 32'(valid), 32'h0);
    mem[5] = 17'h05555; mem[6] = 17'h06666; mem[7] = 17'h0;
    start = 1'b1; start_addr = 8'h05;
    tick();
    start = 1'b0;
    check("t6_resume_halted", 32'(halted), 32'h0);
    check("t6_resume_addr", 32'(address), 32'h05);
    tick();
    check("t6_resume_pc", 32'(out_pc), 32'h05);
    check("t6_resume_instr", 32'(out_instr), 32'h05555);
    check("t6_count", 32'(fcount), 32'h9);

    // asynchronous reset between edges with an instruction held
    ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("t5_async");
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check_reset_values("t5_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
